// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back/write-allocate cache with tree-PLRU replacement
module cache_nway #(
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_byte_enable,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int NODES = NUM_WAYS - 1;

    typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

    state_t state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [SETS-1:0][NUM_WAYS-1:0][255:0] data_q, data_d;
    logic [SETS-1:0][NODES-1:0] plru_q, plru_d;

    logic [S_INDEX-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic req, hit;
    logic [WAY_W-1:0] hit_way, inv_way, plru_way, victim_sel, way_s;
    logic [WAY_W:0] node, walk;
    logic unused;

    assign idx    = mem_address[4+S_INDEX:5];
    assign tag    = mem_address[31:5+S_INDEX];
    assign req    = mem_read | mem_write;
    assign unused = ^mem_address[4:0];

    // Tag compare over the indexed set; victim is lowest invalid way, else the PLRU leaf
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv_way = '0;
        walk    = {{WAY_W{1'b0}}, 1'b1};
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w])
                inv_way = WAY_W'(w);
        end
        for (int l = 0; l < WAY_W; l++)
            walk = {walk[WAY_W-1:0], plru_q[idx][walk[WAY_W-1:0] - WAY_W'(1)]};
        plru_way   = walk[WAY_W-1:0];
        victim_sel = &valid_q[idx] ? plru_way : inv_way;
    end

    // Controller: next state, array updates on hit/fill, and bus outputs
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        plru_d       = plru_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        node         = {{WAY_W{1'b0}}, 1'b1};
        way_s        = hit_way;
        case (state_q)
            IDLE: state_d = req ? CHECK : IDLE;
            CHECK: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    mem_resp  = 1'b1;
                    mem_rdata = data_q[idx][hit_way];
                    for (int l = 0; l < WAY_W; l++) begin
                        plru_d[idx][node[WAY_W-1:0] - WAY_W'(1)] = ~way_s[WAY_W-1];
                        node  = {node[WAY_W-1:0], way_s[WAY_W-1]};
                        way_s = way_s << 1;
                    end
                    if (mem_write) begin
                        for (int b = 0; b < 32; b++)
                            if (mem_byte_enable[b])
                                data_d[idx][hit_way][8*b +: 8] = mem_wdata[8*b +: 8];
                        dirty_d[idx][hit_way] = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    victim_d = victim_sel;
                    state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? WB : FILL;
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, 5'b0};
                pmem_wdata   = data_q[idx][victim_q];
                state_d      = pmem_resp ? FILL : WB;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:5], 5'b0};
                if (pmem_resp) begin
                    data_d[idx][victim_q]  = pmem_rdata;
                    tag_d[idx][victim_q]   = tag;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                    state_d                = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and array registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            plru_q   <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            plru_q   <= plru_d;
        end
    end
endmodule
